// File: rtl/sap_ctrl_sequencer.sv
// SAP-1 microcode control sequencer: T-state counter plus opcode/flag decode into the 16-bit control word.
// Optional per-opcode instruction length is enabled by defining SAP_EARLY_END_EN.
module sap_ctrl_sequencer #(
  parameter int NUM_STEPS = 5
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [3:0]  opcode,
  input  logic        flag_c,
  input  logic        flag_z,
  output logic [15:0] ctrl,
  output logic        pc_load_n,
  output logic        pc_en,
  output logic [2:0]  step,
  output logic        halted
);

  // Control word bit positions, MSB first: HLT MI RI RO IO II AI AO EO SU BI OI CE CO J FI
  localparam logic [15:0] C_HLT = 16'h8000;
  localparam logic [15:0] C_MI  = 16'h4000;
  localparam logic [15:0] C_RI  = 16'h2000;
  localparam logic [15:0] C_RO  = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800;
  localparam logic [15:0] C_II  = 16'h0400;
  localparam logic [15:0] C_AI  = 16'h0200;
  localparam logic [15:0] C_AO  = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080;
  localparam logic [15:0] C_SU  = 16'h0040;
  localparam logic [15:0] C_BI  = 16'h0020;
  localparam logic [15:0] C_OI  = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008;
  localparam logic [15:0] C_CO  = 16'h0004;
  localparam logic [15:0] C_J   = 16'h0002;
  localparam logic [15:0] C_FI  = 16'h0001;

  localparam int CE_BIT = 3;
  localparam int J_BIT  = 1;

  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [2:0] LAST_DEFAULT = 3'(NUM_STEPS - 1);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [2:0] last_step;

`ifdef SAP_EARLY_END_EN
  // Opcode is stable from step 2, and every length is at least 3, so a stale IR during fetch cannot end it early.
  always_comb begin
    last_step = 3'd2;
    case (opcode)
      OP_ADD, OP_SUB: last_step = 3'd4;
      OP_LDA, OP_STA: last_step = 3'd3;
      default:        last_step = 3'd2;
    endcase
  end
`else
  assign last_step = LAST_DEFAULT;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= RUN;
      step_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // HALT leaves step parked at 2; only the asynchronous clear leaves this state.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    if (state_q == RUN) begin
      if (step_q == 3'd2 && opcode == OP_HLT) begin
        state_d = HALT;
      end else if (step_q == last_step) begin
        step_d = 3'd0;
      end else begin
        step_d = step_q + 3'd1;
      end
    end
  end

  always_comb begin
    ctrl = '0;
    if (state_q == HALT) begin
      ctrl = C_HLT;
    end else begin
      case (step_q)
        3'd0: ctrl = C_MI | C_CO;
        3'd1: ctrl = C_RO | C_II | C_CE;
        3'd2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl = C_IO | C_MI;
            OP_LDI: ctrl = C_IO | C_AI;
            OP_JMP: ctrl = C_IO | C_J;
            OP_JC:  ctrl = flag_c ? (C_IO | C_J) : 16'h0000;
            OP_JZ:  ctrl = flag_z ? (C_IO | C_J) : 16'h0000;
            OP_OUT: ctrl = C_AO | C_OI;
            OP_HLT: ctrl = C_HLT;
            default: ctrl = 16'h0000;
          endcase
        end
        3'd3: begin
          case (opcode)
            OP_LDA:         ctrl = C_RO | C_AI;
            OP_ADD, OP_SUB: ctrl = C_RO | C_BI;
            OP_STA:         ctrl = C_AO | C_RI;
            default:        ctrl = 16'h0000;
          endcase
        end
        3'd4: begin
          case (opcode)
            OP_ADD:  ctrl = C_EO | C_AI | C_FI;
            OP_SUB:  ctrl = C_EO | C_AI | C_SU | C_FI;
            default: ctrl = 16'h0000;
          endcase
        end
        default: ctrl = 16'h0000;
      endcase
    end
  end

  assign pc_load_n = ~ctrl[J_BIT];
  assign pc_en     = ctrl[CE_BIT];
  assign step      = step_q;
  assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_sap_ctrl_sequencer.sv
// Self-checking bench for sap_ctrl_sequencer: directed fetch/execute/halt/reset cases plus random
// instruction streams compared against an instruction-table reference model.
module tb_sap_ctrl_sequencer;

  localparam int NUM_STEPS = 5;
`ifdef SAP_EARLY_END_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam logic [15:0] B_HLT = 16'h8000, B_MI = 16'h4000, B_RI = 16'h2000, B_RO = 16'h1000;
  localparam logic [15:0] B_IO  = 16'h0800, B_II = 16'h0400, B_AI = 16'h0200, B_AO = 16'h0100;
  localparam logic [15:0] B_EO  = 16'h0080, B_SU = 16'h0040, B_BI = 16'h0020, B_OI = 16'h0010;
  localparam logic [15:0] B_CE  = 16'h0008, B_CO = 16'h0004, B_J  = 16'h0002, B_FI = 16'h0001;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic        flag_c = 1'b0;
  logic        flag_z = 1'b0;
  logic [15:0] ctrl;
  logic        pc_load_n;
  logic        pc_en;
  logic [2:0]  step;
  logic        halted;

  sap_ctrl_sequencer #(.NUM_STEPS(NUM_STEPS)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .opcode    (opcode),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .ctrl      (ctrl),
    .pc_load_n (pc_load_n),
    .pc_en     (pc_en),
    .step      (step),
    .halted    (halted)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Instruction-level view: each opcode is a list of micro-words; the model only tracks
  // which entry of the current instruction is active and whether the machine stopped.
  int m_step = 0;
  bit m_halted = 1'b0;
  logic [15:0] exp_q[$];

  function automatic logic [15:0] ref_word(input int st, input logic [3:0] op,
                                           input logic c, input logic z, input bit h);
    logic [15:0] w2, w3, w4;
    if (h) return B_HLT;
    if (st == 0) return B_MI | B_CO;
    if (st == 1) return B_RO | B_II | B_CE;
    w2 = 16'h0; w3 = 16'h0; w4 = 16'h0;
    case (op)
      4'h1: begin w2 = B_IO | B_MI; w3 = B_RO | B_AI; end
      4'h2: begin w2 = B_IO | B_MI; w3 = B_RO | B_BI; w4 = B_EO | B_AI | B_FI; end
      4'h3: begin w2 = B_IO | B_MI; w3 = B_RO | B_BI; w4 = B_EO | B_AI | B_SU | B_FI; end
      4'h4: begin w2 = B_IO | B_MI; w3 = B_AO | B_RI; end
      4'h5: w2 = B_IO | B_AI;
      4'h6: w2 = B_IO | B_J;
      4'h7: if (c) w2 = B_IO | B_J;
      4'h8: if (z) w2 = B_IO | B_J;
      4'hE: w2 = B_AO | B_OI;
      4'hF: w2 = B_HLT;
      default: ;
    endcase
    if (st == 2) return w2;
    if (st == 3) return w3;
    if (st == 4) return w4;
    return 16'h0;
  endfunction

  function automatic int ref_len(input logic [3:0] op);
    if (!EARLY) return NUM_STEPS;
    if (op == 4'h2 || op == 4'h3) return 5;
    if (op == 4'h1 || op == 4'h4) return 4;
    return 3;
  endfunction

  // ---------------- driver ----------------
  bit          use_force = 1'b0;
  logic        force_c = 1'b0;
  logic        force_z = 1'b0;
  logic [15:0] last_ctrl;
  logic        last_pl;
  logic [2:0]  last_step;
  logic [15:0] obs_w [0:15];
  logic        obs_pl [0:15];
  logic [2:0]  obs_s [0:15];
  int          n_cyc;

  // Entered and left on a falling edge; drives one cycle and checks every output against the model.
  task automatic run_cycle(input logic [3:0] op);
    logic [15:0] e;
    logic [4:0]  drv;
    if (m_step >= 2 && !m_halted) opcode = op;
    else opcode = 4'($urandom_range(0, 15));
    if (m_step == 2 && use_force && !m_halted) begin
      flag_c = force_c;
      flag_z = force_z;
    end else begin
      flag_c = 1'($urandom_range(0, 1));
      flag_z = 1'($urandom_range(0, 1));
    end
    #1;
    e = ref_word(m_step, opcode, flag_c, flag_z, m_halted);
    exp_q.push_back(e);
    check("step", 32'(step), 32'(m_step));
    check("halted", 32'(halted), 32'(m_halted));
    check("ctrl", 32'(ctrl), 32'(exp_q.pop_front()));
    check("pc_en", 32'(pc_en), 32'((e & B_CE) != 16'h0));
    check("pc_load_n", 32'(pc_load_n), 32'((e & B_J) == 16'h0));
    drv = {ctrl[2], ctrl[12], ctrl[11], ctrl[8], ctrl[7]};
    check("one_bus_driver", 32'($countones(drv) <= 1), 32'(1));
    check("j_and_ce", 32'(ctrl[1] & ctrl[3]), 32'(0));
    last_ctrl = ctrl;
    last_pl   = pc_load_n;
    last_step = step;
    @(posedge clk);
    if (!m_halted) begin
      if (m_step == 2 && opcode == 4'hF) m_halted = 1'b1;
      else if (m_step + 1 >= ref_len(opcode)) m_step = 0;
      else m_step = m_step + 1;
    end
    @(negedge clk);
  endtask

  task automatic do_instr(input logic [3:0] op);
    n_cyc = 0;
    do begin
      run_cycle(op);
      obs_w[n_cyc]  = last_ctrl;
      obs_pl[n_cyc] = last_pl;
      obs_s[n_cyc]  = last_step;
      n_cyc++;
    end while (m_step != 0 && n_cyc < 16);
    if (m_step != 0) check("instr_bound", 32'(m_step), 32'(0));
  endtask

  task automatic reset_dut();
    @(negedge clk);
    clr_n  = 1'b0;
    opcode = 4'($urandom_range(0, 15));
    #1;
    check("rst_step", 32'(step), 32'(0));
    check("rst_ctrl", 32'(ctrl), 32'h4004);
    check("rst_pc_en", 32'(pc_en), 32'(0));
    check("rst_pc_load_n", 32'(pc_load_n), 32'(1));
    check("rst_halted", 32'(halted), 32'(0));
    m_step = 0;
    m_halted = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int total;
  logic [3:0] prog [0:3];

  initial begin
    reset_dut();

    // fetch words and default-length step walk using a NOP
    do_instr(4'h0);
    check("fetch_w0", 32'(obs_w[0]), 32'h4004);
    check("fetch_w1", 32'(obs_w[1]), 32'h1408);
    check("nop_len", 32'(n_cyc), EARLY ? 32'(3) : 32'(5));
    for (int i = 0; i < n_cyc; i++) check("nop_step_seq", 32'(obs_s[i]), 32'(i));

    // ADD / SUB execute words
    do_instr(4'h2);
    check("add_s2", 32'(obs_w[2]), 32'h4800);
    check("add_s3", 32'(obs_w[3]), 32'h1020);
    check("add_s4", 32'(obs_w[4]), 32'h0281);
    for (int i = 2; i < 5; i++) check("add_no_j_ce", 32'(obs_w[i] & 16'h000A), 32'h0);
    do_instr(4'h3);
    check("sub_s4", 32'(obs_w[4]), 32'h02C1);

    // conditional jumps, flags forced only in step 2
    use_force = 1'b1;
    force_c = 1'b1; force_z = 1'b0;
    do_instr(4'h7);
    check("jc_taken_ctrl", 32'(obs_w[2]), 32'h0802);
    check("jc_taken_pl", 32'(obs_pl[2]), 32'(0));
    check("jc_taken_len", 32'(n_cyc), EARLY ? 32'(3) : 32'(5));
    force_c = 1'b0; force_z = 1'b1;
    do_instr(4'h7);
    check("jc_not_ctrl", 32'(obs_w[2]), 32'h0000);
    check("jc_not_pl", 32'(obs_pl[2]), 32'(1));
    check("jc_not_len", 32'(n_cyc), EARLY ? 32'(3) : 32'(5));
    do_instr(4'h8);
    check("jz_taken_ctrl", 32'(obs_w[2]), 32'h0802);
    use_force = 1'b0;

    // early-end program: LDI, STA, NOP, OUT
    prog[0] = 4'h5; prog[1] = 4'h4; prog[2] = 4'h0; prog[3] = 4'hE;
    total = 0;
    for (int i = 0; i < 4; i++) begin
      do_instr(prog[i]);
      total += n_cyc;
    end
    check("prog_total", 32'(total), EARLY ? 32'(13) : 32'(20));

    // random instruction stream, undefined opcodes included
    for (int i = 0; i < 80; i++) do_instr(4'($urandom_range(0, 14)));

    // asynchronous clear in step 3 of LDA, between edges
    run_cycle(4'h1);
    run_cycle(4'h1);
    run_cycle(4'h1);
    check("lda_at_step3", 32'(step), 32'(3));
    clr_n = 1'b0;
    #1;
    check("async_step", 32'(step), 32'(0));
    check("async_ctrl", 32'(ctrl), 32'h4004);
    m_step = 0;
    m_halted = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    do_instr(4'h1);

    // halt, then 20 cycles of toggled inputs, then clear
    run_cycle(4'hF);
    run_cycle(4'hF);
    run_cycle(4'hF);
    check("hlt_word", 32'(last_ctrl), 32'h8000);
    for (int i = 0; i < 20; i++) run_cycle(4'($urandom_range(0, 15)));
    check("hlt_frozen_step", 32'(step), 32'(2));
    check("hlt_halted", 32'(halted), 32'(1));
    check("hlt_pc_en", 32'(pc_en), 32'(0));
    clr_n = 1'b0;
    #1;
    check("hlt_clr_step", 32'(step), 32'(0));
    check("hlt_clr_halted", 32'(halted), 32'(0));
    m_step = 0;
    m_halted = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    do_instr(4'h6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
